// File: rtl/procedural_result_accum.sv
// procedural_result_accum
//   Groups BURST_LEN result pairs from an upstream compute stage into one
//   summary: sum1 is the sum of res1 (unsigned), chk2 is the XOR-fold of
//   res2, and ovf records that the sum carried out of ACC_W bits.
//
// Parameters
//   BURST_LEN  beats per burst (2..255)
//   ACC_W      accumulator width (17..32)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream result pair valid
//   in_ready   block accepts a pair (high in IDLE/ACCUM, low in EMIT)
//   res1       primary result, unsigned
//   res2       secondary result
//   out_valid  summary valid (registered, one cycle after last beat)
//   out_ready  downstream accepts summary
//   sum1       accumulated res1
//   chk2       XOR-fold of res2
//   ovf        sum1 overflowed ACC_W bits during the burst
//   busy       state is not IDLE
//
// Configuration macro
//   PROCEDURAL_ACCUM_SAT_EN  defined: accumulator saturates at all-ones on
//                            overflow; undefined: accumulator wraps.
//                            ovf is flagged in both builds.

module procedural_result_accum #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ACC_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      res1,
    input  logic [15:0]      res2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum1,
    output logic [15:0]      chk2,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc1_q, acc1_d;
    logic [15:0]       acc2_q, acc2_d;
    logic              acc_ovf_q, acc_ovf_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  sum1_q, sum1_d;
    logic [15:0]       chk2_q, chk2_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic [ACC_W:0]    sum_ext;
    logic [ACC_W-1:0]  acc1_next;
    logic [15:0]       acc2_next;
    logic              ovf_next;

    assign in_ready  = (state_q != EMIT);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum1      = sum1_q;
    assign chk2      = chk2_q;
    assign ovf       = ovf_q;

    assign accept  = in_valid & in_ready;
    assign sum_ext = {1'b0, acc1_q} + (ACC_W+1)'(res1);

    // Running accumulation for a beat taken in ACCUM. Once saturated, any
    // further non-zero addend carries again, so the value stays pinned.
    always_comb begin
        acc2_next = acc2_q ^ res2;
        ovf_next  = acc_ovf_q | sum_ext[ACC_W];
`ifdef PROCEDURAL_ACCUM_SAT_EN
        acc1_next = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
        acc1_next = sum_ext[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        acc_ovf_d   = acc_ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        sum1_d      = sum1_q;
        chk2_d      = chk2_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc1_d    = ACC_W'(res1);
                    acc2_d    = res2;
                    acc_ovf_d = 1'b0;
                    cnt_d     = 8'd1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc1_d    = acc1_next;
                    acc2_d    = acc2_next;
                    acc_ovf_d = ovf_next;
                    cnt_d     = cnt_q + 8'd1;
                    // Summary registers are loaded with the final values
                    // here so they sit stable for the whole EMIT state and
                    // hold between bursts.
                    if (cnt_q + 8'd1 == 8'(BURST_LEN)) begin
                        state_d     = EMIT;
                        out_valid_d = 1'b1;
                        sum1_d      = acc1_next;
                        chk2_d      = acc2_next;
                        ovf_d       = ovf_next;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc1_q      <= '0;
            acc2_q      <= '0;
            acc_ovf_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sum1_q      <= '0;
            chk2_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            acc_ovf_q   <= acc_ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sum1_q      <= sum1_d;
            chk2_q      <= chk2_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: doc/procedural_result_accum.md
PROCEDURAL_RESULT_ACCUM -- requirements
Module: procedural_result_accum

Interface
REQ-001 SHALL provide parameter BURST_LEN, default 4, giving the number of result beats per burst; legal range 2..255.
REQ-002 SHALL provide parameter ACC_W, default 24, giving the accumulator width; legal range 17..32.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port in_valid  input  1  upstream result pair valid.
REQ-006 SHALL provide port in_ready  output  1  block can accept a result pair.
REQ-007 SHALL provide port res1  input  16  upstream primary result (out1 of the compute stage), unsigned.
REQ-008 SHALL provide port res2  input  16  upstream secondary result (out2 of the compute stage).
REQ-009 SHALL provide port out_valid  output  1  burst summary valid.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts summary.
REQ-011 SHALL provide port sum1  output  ACC_W  accumulated res1 over the burst.
REQ-012 SHALL provide port chk2  output  16  XOR-fold of res2 over the burst.
REQ-013 SHALL provide port ovf  output  1  sum1 exceeded ACC_W bits during the burst.
REQ-014 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM and EMIT.
REQ-016 SHALL accept a beat when in_valid and in_ready are both high in the same cycle; cycles with in_valid low do not count.
REQ-017 SHALL drive in_ready high in IDLE and ACCUM and low in EMIT (combinational from state).
REQ-018 In IDLE, an accepted beat SHALL load acc1=zero-extended res1, chk2=res2, cnt=1, ovf=0, and move to ACCUM.
REQ-019 In ACCUM, each accepted beat SHALL do acc1+=res1, chk2^=res2, cnt+=1, and set ovf sticky if the addition carries out of ACC_W.
REQ-020 When the accepted beat is beat number BURST_LEN, the FSM SHALL move to EMIT, with out_valid registered high on the next cycle (one-cycle latency after the last beat).
REQ-021 In EMIT, sum1, chk2 and ovf SHALL be held stable while out_valid is high and out_ready is low.
REQ-022 In EMIT with out_ready high, the FSM SHALL return to IDLE; out_valid falls the next cycle, and the next beat is accepted no earlier than that cycle.
REQ-023 Without the configuration macro, acc1 SHALL wrap modulo 2^ACC_W on overflow.
REQ-024 sum1, chk2 and ovf SHALL hold their last values outside EMIT; they are meaningful only while out_valid is high.

Reset
REQ-025 While rst_n is low at a clock edge: state=IDLE, out_valid=0, busy=0, cnt=0, sum1=0, chk2=0, ovf=0.
REQ-026 Reset mid-burst SHALL discard partial accumulation; the next accepted beat starts a fresh burst.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro PROCEDURAL_ACCUM_SAT_EN defined: acc1 SHALL saturate at 2^ACC_W-1 on overflow and stay there for the rest of the burst, with ovf=1.
REQ-029 Macro PROCEDURAL_ACCUM_SAT_EN undefined: wrapping per REQ-023, with ovf still flagged.

Verification
REQ-030 Basic burst (BURST_LEN=4): res1=1,2,3,4; res2=0x00FF,0x0F0F,0xF000,0x0001 -> out_valid one cycle after 4th beat, sum1=10, chk2=0xFFF1, ovf=0.
REQ-031 Overflow (ACC_W=17): res1=0xFFFF x4 -> sum1=0x1FFFC and ovf=1 without the macro; sum1=0x1FFFF and ovf=1 with it.
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in EMIT with in_valid=1 -> in_ready=0, no beat accepted, sum1/chk2 stable; release -> IDLE next cycle.
REQ-033 Bubbles: in_valid pattern 1,0,0,1,0,1,1 with res1=5 each -> exactly 4 beats counted, sum1=20.
REQ-034 Reset mid-burst: rst_n low for 1 cycle after 2 beats -> busy=0; the following burst res1=1,1,1,1 gives sum1=4.
REQ-035 Back-to-back: out_ready tied high with continuous in_valid -> consecutive summaries separated by exactly one non-accepting EMIT cycle, with no beat lost.
